// File: rtl/cve2_obi_arbiter.sv
// -----------------------------------------------------------------------------
// cve2_obi_arbiter
//
// Two-to-one OBI arbiter that merges the core's instruction and data ports
// onto one shared memory port. Requests are forwarded combinationally. An
// ungranted address phase is locked to its master until it is granted. A
// small route FIFO remembers which side issued each accepted transaction, so
// the in-order responses can be steered back to the right side.
//
// Parameters
//   MaxOutstanding : accepted-but-unanswered transactions allowed (1..8)
//   ArbMode        : 0 = fixed priority (data over instr), 1 = round-robin
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   instr_*              instruction-side OBI slave port (read only)
//   data_*               data-side OBI slave port
//   mem_*                shared OBI master port towards memory / bus
//   outstanding_o        current number of in-flight transactions
//   idle_o               no transaction in flight and no request pending
// -----------------------------------------------------------------------------
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned ArbMode        = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic [3:0]  outstanding_o,
  output logic        idle_o
);

  // Pointer width is at least one bit; storage is rounded up to a power of
  // two so any pointer value indexes a real entry. Only the first
  // MaxOutstanding entries are ever used because the pointers wrap early.
  localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned Entries = 1 << PtrW;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(MaxOutstanding - 1);
  localparam logic [3:0]      MaxCnt  = 4'(MaxOutstanding);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_d_q;
  logic              sel_data;
  logic              sel_req;
  logic              push, pop;
  logic              head_data;
  logic [3:0]        count_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [Entries-1:0] route_q;

  // ---------------------------------------------------------------------------
  // Side selection
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    sel_data = 1'b0;
    unique case (state_q)
      HOLD_I: sel_data = 1'b0;
      HOLD_D: sel_data = 1'b1;
      default: begin
        if (ArbMode == 0) begin
          sel_data = data_req_i;
        end else if (data_req_i && instr_req_i) begin
          // Tie: whoever was not served last goes first.
          sel_data = ~last_d_q;
        end else begin
          sel_data = data_req_i;
        end
      end
    endcase
  end

  assign sel_req = sel_data ? data_req_i : instr_req_i;

  // The full check uses the registered count only, so a response arriving
  // in the same cycle cannot combinationally re-open the request path.
  assign mem_req_o = rst_ni & sel_req & (count_q < MaxCnt);

  assign push = mem_req_o & mem_gnt_i;
  // A response with nothing in flight is spurious and simply dropped.
  assign pop  = rst_ni & mem_rvalid_i & (count_q != 4'd0);

  // ---------------------------------------------------------------------------
  // Address-phase lock state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = sel_data ? HOLD_D : HOLD_I;
        end
      end
      HOLD_I, HOLD_D: begin
        // Release on grant; also release if the locked master withdraws its
        // request so the arbiter can never wedge on an idle side.
        if (!mem_req_o || mem_gnt_i) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      last_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        last_d_q <= sel_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Route FIFO: one bit per in-flight transaction, 1 = data side
  // ---------------------------------------------------------------------------
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the route storage itself is not reset; an entry is only read while
  // the occupancy count says it holds a live value, and the count is reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      route_q[wr_ptr_q] <= sel_data;
    end
  end

  assign head_data = route_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Grants, payload mux and response routing
  // ---------------------------------------------------------------------------
  assign instr_gnt_o = push & ~sel_data;
  assign data_gnt_o  = push &  sel_data;

  assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = sel_data ? data_we_i    : 1'b0;
  assign mem_be_o    = sel_data ? data_be_i    : 4'hF;
  assign mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

  assign instr_rvalid_o = pop & ~head_data;
  assign data_rvalid_o  = pop &  head_data;

  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign instr_err_o   = mem_err_i;
  assign data_err_o    = mem_err_i;

  assign outstanding_o = count_q;
  assign idle_o        = (count_q == 4'd0) & ~instr_req_i & ~data_req_i;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  count_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= MaxCnt)
    else $error("outstanding count exceeds MaxOutstanding");

  spurious_rvalid_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && (count_q == 4'd0)))
    else $warning("response with no transaction in flight was dropped");

endmodule
